// File: rtl/mem_stage_hs_if.sv
// Data-memory bus between the MEM stage and data memory: a valid/ready request
// channel plus a response-valid channel carrying read data or a write acknowledge.
interface mem_stage_hs_if #(
    parameter int XLEN    = 32,
    parameter int WSTRB_W = XLEN / 8
);
    logic               mem_req_valid;
    logic               mem_req_ready;
    logic [XLEN-1:0]    mem_addr;
    logic               mem_we;
    logic [XLEN-1:0]    mem_wdata;
    logic [WSTRB_W-1:0] mem_wstrb;
    logic               mem_rsp_valid;
    logic [XLEN-1:0]    mem_rdata;

    modport master (
        output mem_req_valid, mem_addr, mem_we, mem_wdata, mem_wstrb,
        input  mem_req_ready, mem_rsp_valid, mem_rdata
    );

    modport slave (
        input  mem_req_valid, mem_addr, mem_we, mem_wdata, mem_wstrb,
        output mem_req_ready, mem_rsp_valid, mem_rdata
    );
endinterface

// File: rtl/mem_stage_hs.sv
// MEM pipeline stage with a handshaked, variable-latency data-memory port; stalls
// upstream while an access is in flight. Define MEM_MISALIGN_TRAP_EN to flag misaligned accesses.
module mem_stage_hs #(
    parameter int          XLEN     = 32,
    parameter int          WSTRB_W  = XLEN / 8,
    parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic [31:0]       instruction,
    input  logic [XLEN-1:0]   instruction_address,
    input  logic [XLEN-1:0]   alu_result,
    input  logic [XLEN-1:0]   reg2_data,
    input  logic              memory_read_enable,
    input  logic              memory_write_enable,
    input  logic              reg_write_enable,
    input  logic [4:0]        reg_write_address,
    output logic              stall,
    mem_stage_hs_if.master    mem,
    output logic              wb_valid,
    output logic [XLEN-1:0]   wb_data,
    output logic [31:0]       wb_instruction,
    output logic [XLEN-1:0]   wb_instruction_address,
    output logic              wb_reg_write_enable,
    output logic [4:0]        wb_reg_write_address,
    output logic              wb_misaligned
);
    localparam int OFF_W = $clog2(WSTRB_W);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
    state_t state_q, state_d;

    logic [2:0]      funct3;
    logic            is_mem, f3_legal, trap, mem_go, in_idle;
    logic [XLEN-1:0] size_lo, addr_aligned;
    logic            req_valid, wb_take_mem;

    logic [XLEN-1:0]    hold_addr_p0, hold_alu_p0, hold_wdata_p0, hold_pc_p0;
    logic [WSTRB_W-1:0] hold_wstrb_p0;
    logic [2:0]         hold_f3_p0;
    logic               hold_we_p0, hold_rwe_p0;
    logic [4:0]         hold_rd_p0;
    logic [31:0]        hold_insn_p0;

    function automatic logic [XLEN-1:0] store_lanes(input logic [XLEN-1:0] d,
                                                    input logic [1:0] sz,
                                                    input logic [OFF_W-1:0] off);
        logic [63:0] d64;
        d64 = 64'(d);
        case (sz)
            2'd0:    d64 = {56'd0, d64[7:0]};
            2'd1:    d64 = {48'd0, d64[15:0]};
            2'd2:    d64 = {32'd0, d64[31:0]};
            default: d64 = d64;
        endcase
        d64 = d64 << {off, 3'b000};
        return d64[XLEN-1:0];
    endfunction

    function automatic logic [WSTRB_W-1:0] store_strobe(input logic [1:0] sz,
                                                        input logic [OFF_W-1:0] off);
        logic [7:0] s;
        case (sz)
            2'd0:    s = 8'h01;
            2'd1:    s = 8'h03;
            2'd2:    s = 8'h0F;
            default: s = 8'hFF;
        endcase
        s = s << off;
        return s[WSTRB_W-1:0];
    endfunction

    function automatic logic [XLEN-1:0] load_extract(input logic [XLEN-1:0] rdata,
                                                     input logic [2:0] f3,
                                                     input logic [OFF_W-1:0] off);
        logic [63:0]        r64;
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic signed [31:0] w;
        logic signed [63:0] x;
        r64 = 64'(rdata) >> {off, 3'b000};
        b   = r64[7:0];
        h   = r64[15:0];
        w   = r64[31:0];
        case (f3)
            3'b000:  x = 64'(b);
            3'b100:  x = {56'd0, r64[7:0]};
            3'b001:  x = 64'(h);
            3'b101:  x = {48'd0, r64[15:0]};
            3'b010:  x = 64'(w);
            3'b110:  x = {32'd0, r64[31:0]};
            default: x = r64;
        endcase
        return x[XLEN-1:0];
    endfunction

    assign funct3   = instruction[14:12];
    assign is_mem   = memory_read_enable | memory_write_enable;
    assign f3_legal = (funct3 != 3'b111) &&
                      ((XLEN == 64) || ((funct3 != 3'b011) && (funct3 != 3'b110)));
    assign in_idle  = (state_q == IDLE);

    always_comb begin
        case (funct3[1:0])
            2'd0:    size_lo = '0;
            2'd1:    size_lo = XLEN'(1);
            2'd2:    size_lo = XLEN'(3);
            default: size_lo = XLEN'(7);
        endcase
    end

    // Without the trap, misaligned low bits are simply dropped for the access size.
    assign addr_aligned = alu_result & ~size_lo;

`ifdef MEM_MISALIGN_TRAP_EN
    assign trap = is_mem && f3_legal && (|(alu_result[2:0] & size_lo[2:0]));
`else
    assign trap = 1'b0;
`endif

    assign mem_go = ex_valid && is_mem && f3_legal && !trap;

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        stall       = 1'b0;
        req_valid   = 1'b0;
        wb_take_mem = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_go) begin
                    stall   = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                stall     = 1'b1;
                req_valid = 1'b1;
                if (mem.mem_req_ready) state_d = WAIT;
            end
            WAIT: begin
                if (mem.mem_rsp_valid) begin
                    wb_take_mem = 1'b1;
                    state_d     = IDLE;
                end else begin
                    stall = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Stage p0: hold registers that keep the request stable across the handshake.
    always_ff @(posedge clk) begin
        if (in_idle && mem_go) begin
            hold_addr_p0  <= addr_aligned;
            hold_alu_p0   <= alu_result;
            hold_we_p0    <= ~memory_read_enable;
            hold_wdata_p0 <= store_lanes(reg2_data, funct3[1:0], addr_aligned[OFF_W-1:0]);
            hold_wstrb_p0 <= memory_read_enable ? '0
                           : store_strobe(funct3[1:0], addr_aligned[OFF_W-1:0]);
            hold_f3_p0    <= funct3;
            hold_rwe_p0   <= reg_write_enable;
            hold_rd_p0    <= reg_write_address;
            hold_pc_p0    <= instruction_address;
            hold_insn_p0  <= instruction;
        end
    end

    assign mem.mem_req_valid = req_valid;
    assign mem.mem_addr      = {hold_addr_p0[XLEN-1:OFF_W], {OFF_W{1'b0}}};
    assign mem.mem_we        = hold_we_p0;
    assign mem.mem_wdata     = hold_wdata_p0;
    assign mem.mem_wstrb     = hold_wstrb_p0;

    // Stage p1: MEM/WB boundary registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid               <= 1'b0;
            wb_data                <= '0;
            wb_instruction         <= NOP_INSN;
            wb_instruction_address <= '0;
            wb_reg_write_enable    <= 1'b0;
            wb_reg_write_address   <= '0;
        end else if (wb_take_mem) begin
            wb_valid               <= 1'b1;
            wb_data                <= hold_we_p0 ? hold_alu_p0
                                    : load_extract(mem.mem_rdata, hold_f3_p0, hold_addr_p0[OFF_W-1:0]);
            wb_instruction         <= hold_insn_p0;
            wb_instruction_address <= hold_pc_p0;
            wb_reg_write_enable    <= hold_rwe_p0 & ~hold_we_p0;
            wb_reg_write_address   <= hold_rd_p0;
        end else if (in_idle && ex_valid && !mem_go) begin
            wb_valid               <= 1'b1;
            wb_instruction         <= instruction;
            wb_instruction_address <= instruction_address;
            wb_reg_write_address   <= reg_write_address;
            if (is_mem && !f3_legal) begin
                wb_data             <= '0;
                wb_reg_write_enable <= 1'b0;
            end else begin
                wb_data             <= alu_result;
                wb_reg_write_enable <= reg_write_enable & ~trap;
            end
        end else begin
            wb_valid            <= 1'b0;
            wb_reg_write_enable <= 1'b0;
            wb_instruction      <= NOP_INSN;
        end
    end

`ifdef MEM_MISALIGN_TRAP_EN
    always_ff @(posedge clk) begin
        if (rst) wb_misaligned <= 1'b0;
        else     wb_misaligned <= in_idle && ex_valid && trap;
    end
`else
    assign wb_misaligned = 1'b0;
`endif

endmodule

// File: doc/mem_stage_hs.md
Name: mem_stage_hs

Overview:
- Memory-access pipeline stage, successor to the combinational MEM stage; sits between the EX/MEM and MEM/WB boundaries of the five-stage core.
- Data width is parametrised (XLEN 32 or 64).
- Talks to data memory over a valid/ready request channel and a response-valid channel with variable latency, and stalls the upstream pipeline while an access is in flight.
- All MEM/WB outputs are registered.

Parameters:
- XLEN, 32, datapath and bus width; legal values 32 or 64.
- WSTRB_W, XLEN/8, byte-strobe width.
- NOP_INSN, 32'h0000_0013, instruction word driven on bubbles and during reset.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- ex_valid  in  1  EX/MEM slot holds a real instruction.
- instruction  in  32  instruction word; funct3 = instruction[14:12].
- instruction_address  in  XLEN  PC of the instruction.
- alu_result  in  XLEN  effective byte address, or ALU result for non-memory ops.
- reg2_data  in  XLEN  store data.
- memory_read_enable  in  1  load.
- memory_write_enable  in  1  store.
- reg_write_enable  in  1  rd write enable.
- reg_write_address  in  5  rd.
- stall  out  1  upstream must hold all inputs stable.
- mem_req_valid  out  1  request valid.
- mem_req_ready  in  1  memory accepts the request.
- mem_addr  out  XLEN  byte address, low log2(WSTRB_W) bits zero.
- mem_we  out  1  1 = write.
- mem_wdata  out  XLEN  lane-shifted store data.
- mem_wstrb  out  WSTRB_W  byte enables; zero for reads.
- mem_rsp_valid  in  1  read data valid or write acknowledge.
- mem_rdata  in  XLEN  full bus word.
- wb_valid  out  1  MEM/WB slot holds a real instruction.
- wb_data  out  XLEN  load result, or alu_result for non-memory ops.
- wb_instruction  out  32  instruction word.
- wb_instruction_address  out  XLEN  PC.
- wb_reg_write_enable  out  1  rd write enable.
- wb_reg_write_address  out  5  rd.
- wb_misaligned  out  1  misaligned-access flag (optional feature only; tied 0 otherwise).

Behaviour:
- Reset (synchronous): state IDLE, mem_req_valid 0, stall 0, wb_valid 0, wb_data 0, wb_instruction NOP_INSN, wb_instruction_address 0, wb_reg_write_enable 0, wb_reg_write_address 0, wb_misaligned 0.
- Reset mid-access: abandons the access; a late mem_rsp_valid seen in IDLE is ignored.
- FSM states: IDLE, REQ, WAIT.
- IDLE, non-memory op with ex_valid=1: on the next edge load the WB registers (wb_data = alu_result, wb_valid = 1); stall = 0; latency 1.
- IDLE, ex_valid=0: next edge wb_valid = 0, wb_reg_write_enable = 0, wb_instruction = NOP_INSN.
- IDLE, memory op with ex_valid=1 and a legal funct3:
  - stall = 1 combinationally.
  - On the edge, capture address, data, funct3, rd, PC and instruction into hold registers.
  - Go to REQ; wb_valid = 0 on that edge.
- REQ: mem_req_valid = 1; mem_addr, mem_we, mem_wdata and mem_wstrb are driven from the hold registers and stay stable until mem_req_ready. When mem_req_valid & mem_req_ready, go to WAIT at the edge. stall = 1.
- WAIT: mem_req_valid = 0.
  - mem_rsp_valid = 0: stall = 1.
  - mem_rsp_valid = 1: stall = 0 in that cycle; on the edge load the WB registers, set wb_valid = 1, return to IDLE.
- Stores also wait for mem_rsp_valid; a store writes wb_reg_write_enable = 0.
- mem_rsp_valid is ignored outside WAIT. The earliest response is the cycle after acceptance.
- Minimum load latency from presentation to wb_valid: 3 cycles.
- Load extraction, with off = address[log2(WSTRB_W)-1:0] selecting the byte lane of mem_rdata:
  - funct3 000 LB, sign-extend.
  - funct3 100 LBU, zero-extend.
  - funct3 001 LH, sign-extend.
  - funct3 101 LHU, zero-extend.
  - funct3 010 LW, sign-extend to XLEN.
  - funct3 110 LWU, XLEN=64 only, zero-extend.
  - funct3 011 LD, XLEN=64 only.
- Store: mem_wdata = reg2_data[size-1:0] << (off*8). mem_wstrb = (2^bytes - 1) << off, for SB/SH/SW/SD (SD only when XLEN=64).
- Illegal funct3 (funct3 111 always, or 011/110 when XLEN=32) with a memory enable: no request, treated as a non-memory op with wb_reg_write_enable forced 0, wb_data = 0.
- memory_read_enable and memory_write_enable both 1: treated as a load.

Optional Feature:
- MEM_MISALIGN_TRAP_EN defined:
  - A misaligned access is one where (half and address[0]), or (word and address[1:0] != 0), or (dword and address[2:0] != 0).
  - Such an access issues no request and raises no stall.
  - Next edge: wb_valid = 1, wb_misaligned = 1, wb_reg_write_enable = 0, wb_data = alu_result.
- MEM_MISALIGN_TRAP_EN not defined:
  - The offending low bits are forced to zero for that access size (LH at ...3 is treated as ...2).
  - wb_misaligned is tied 0.

Test Plan:
- Reset for 2 cycles, then ex_valid=0 -> all WB outputs hold reset values; wb_instruction = 0x00000013.
- XLEN=32, LB at 0x1003, mem_rdata = 0x80FF_0000, ready immediate, rsp 1 cycle later -> wb_data = 0xFFFF_FF80, wb_valid exactly 3 cycles after presentation, stall high for exactly 2 cycles.
- SH at 0x2002, reg2_data = 0x1234_ABCD -> mem_wdata = 0xABCD_0000, mem_wstrb = 4'b1100, mem_we = 1; ready delayed 3 cycles -> request fields stable throughout, stall stays 1.
- XLEN=64, LWU at 0x...4, mem_rdata = 0x8765_4321_0000_0000 -> wb_data = 0x0000_0000_8765_4321.
- rst asserted in WAIT, then mem_rsp_valid pulsed the following cycle -> state IDLE, wb_valid = 0, response ignored.
- With MEM_MISALIGN_TRAP_EN, LW at 0x3001 -> mem_req_valid never asserts, next-cycle wb_misaligned = 1, wb_reg_write_enable = 0. Without the macro, same stimulus -> mem_addr = 0x3000, normal load.
